// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the pixel SRAM arbiter.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 16;
    localparam int SRAM_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    typedef struct packed {
        logic                   write;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the
// pointer, wrapping to index 0. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        // First pass covers ptr..NUM_REQ-1, second pass wraps from 0.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!any_o && valid_i[j] && (IDX_W'(j) >= ptr_i)) begin
                any_o      = 1'b1;
                idx_o      = IDX_W'(j);
                grant_o[j] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!any_o && valid_i[j]) begin
                any_o      = 1'b1;
                idx_o      = IDX_W'(j);
                grant_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin sharing of the single-port pixel SRAM between NUM_REQ requesters.
// Optional per-requester grant counters are enabled by defining SRAM_ARB_STATS_EN.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int ADDR_W        = SRAM_ADDR_W,
    parameter int DATA_W        = SRAM_DATA_W,
    parameter int ACCESS_CYCLES = 2,
    parameter int TURN_CYCLES   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      busy,
    output logic                      read_enable,
    output logic                      write_enable,
    output logic [ADDR_W-1:0]         address,
    output logic [DATA_W-1:0]         w_data,
    input  logic [DATA_W-1:0]         r_data
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     grant_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CMAX  = (ACCESS_CYCLES > TURN_CYCLES) ? ACCESS_CYCLES : TURN_CYCLES;
    localparam int CNT_W = $clog2(CMAX + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic                write_q, write_d;
    logic                read_enable_q, read_enable_d;
    logic                write_enable_q, write_enable_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ptr_d          = ptr_q;
        gidx_d         = gidx_q;
        write_d        = write_q;
        read_enable_d  = read_enable_q;
        write_enable_d = write_enable_q;
        address_d      = address_q;
        w_data_d       = w_data_q;
        rsp_valid_d    = '0;
        rsp_rdata_d    = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d        = ACCESS;
                    cnt_d          = '0;
                    gidx_d         = arb_idx;
                    write_d        = sel_write;
                    address_d      = sel_addr;
                    w_data_d       = sel_wdata;
                    read_enable_d  = !sel_write;
                    write_enable_d = sel_write;
                    ptr_d          = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_W'(ACCESS_CYCLES - 1)) begin
                    state_d        = RECOVER;
                    cnt_d          = '0;
                    read_enable_d  = 1'b0;
                    write_enable_d = 1'b0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (gidx_q == IDX_W'(i)) rsp_valid_d[i] = 1'b1;
                    end
                    // r_data is captured on the edge that closes the last access cycle.
                    if (!write_q) rsp_rdata_d = r_data;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == CNT_W'(TURN_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d        = IDLE;
                cnt_d          = '0;
                read_enable_d  = 1'b0;
                write_enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            ptr_q          <= '0;
            gidx_q         <= '0;
            write_q        <= 1'b0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            address_q      <= '0;
            w_data_q       <= '0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ptr_q          <= ptr_d;
            gidx_q         <= gidx_d;
            write_q        <= write_d;
            read_enable_q  <= read_enable_d;
            write_enable_q <= write_enable_d;
            address_q      <= address_d;
            w_data_q       <= w_data_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
        end
    end

    // Accept pulse is the only output decoded from live inputs; masked in reset.
    assign req_ready    = (state_q == IDLE && !rst) ? arb_grant : '0;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign busy         = (state_q != IDLE);
    assign read_enable  = read_enable_q;
    assign write_enable = write_enable_q;
    assign address      = address_q;
    assign w_data       = w_data_q;

`ifdef SRAM_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] gcnt_q, gcnt_d;

    always_comb begin
        gcnt_d = gcnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && (gcnt_q[i*16 +: 16] != 16'hFFFF)) begin
                gcnt_d[i*16 +: 16] = gcnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) gcnt_q <= '0;
        else     gcnt_q <= gcnt_d;
    end

    assign grant_count = gcnt_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table of single accesses, a
// response scoreboard, and hand sequences for round-robin and mid-access reset.
module tb_sram_arbiter;

    localparam int NR = 2;
    localparam int AW = 16;
    localparam int DW = 24;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_write = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            busy;
    logic            read_enable;
    logic            write_enable;
    logic [AW-1:0]   address;
    logic [DW-1:0]   w_data;
    logic [DW-1:0]   r_data;
`ifdef SRAM_ARB_STATS_EN
    logic [NR*16-1:0] grant_count;
`endif

    sram_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2), .TURN_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .read_enable(read_enable), .write_enable(write_enable),
        .address(address), .w_data(w_data), .r_data(r_data)
`ifdef SRAM_ARB_STATS_EN
        , .grant_count(grant_count)
`endif
    );

    always #6 clk = ~clk;

    // SRAM model: combinational read while strobed, write on each strobed edge.
    logic [DW-1:0] mem [0:65535];
    assign r_data = read_enable ? mem[address] : '0;
    always @(posedge clk) if (write_enable) mem[address] <= w_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_gc [NR];

    typedef struct {
        int          req;
        bit          chk_data;
        logic [23:0] rdata;
    } sb_t;
    sb_t sbq [$];
    sb_t mon_e;

    typedef struct {
        int          r;
        bit          w;
        logic [15:0] a;
        logic [23:0] d;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("enables_exclusive", 32'(read_enable & write_enable), 0);
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: actual rsp_valid %0h required none", rsp_valid);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sb_rsp_idx", 32'(rsp_valid), 32'(1 << mon_e.req));
                    if (mon_e.chk_data) chk("sb_rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                end
            end
        end
    end

    task automatic do_txn(input int r, input bit w, input logic [15:0] a,
                          input logic [23:0] d, input logic [23:0] exp);
        bit  got;
        sb_t e;
        @(negedge clk);
        req_write[r]           = w;
        req_addr[r*AW +: AW]   = a;
        req_wdata[r*DW +: DW]  = d;
        req_valid[r]           = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            #1;
            if (req_ready[r]) got = 1'b1;
            else @(negedge clk);
        end
        chk($sformatf("grant_r%0d_%0h", r, a), 32'(got), 1);
        if (!got) begin
            req_valid[r] = 1'b0;
            return;
        end
        exp_gc[r]++;
        e.req = r; e.chk_data = !w; e.rdata = exp;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid[r] = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            if (k == 2) @(negedge clk);
            chk($sformatf("acc%0d_rd_en", k), 32'(read_enable), 32'(!w));
            chk($sformatf("acc%0d_wr_en", k), 32'(write_enable), 32'(w));
            chk($sformatf("acc%0d_addr", k), 32'(address), 32'(a));
            if (w) chk($sformatf("acc%0d_wdata", k), 32'(w_data), 32'(d));
            chk($sformatf("acc%0d_rsp_quiet", k), 32'(rsp_valid), 0);
            chk($sformatf("acc%0d_busy", k), 32'(busy), 1);
        end
        @(negedge clk);
        chk("rec_rsp_valid", 32'(rsp_valid), 32'(1 << r));
        chk("rec_enables_low", 32'({read_enable, write_enable}), 0);
        if (!w) chk("rec_rdata", 32'(rsp_rdata), 32'(exp));
        else    chk("mem_written", 32'(mem[a]), 32'(d));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rsp_quiet", 32'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        int last;
        int r;
        sb_t e;

        vecs[0] = '{0, 1'b0, 16'h0005, 24'h000000, 24'h123456};
        vecs[1] = '{1, 1'b1, 16'h0000, 24'hE0FEE9, 24'h000000};
        vecs[2] = '{0, 1'b0, 16'h0000, 24'h000000, 24'hE0FEE9};
        vecs[3] = '{1, 1'b1, 16'h0010, 24'hBBBFBB, 24'h000000};
        vecs[4] = '{0, 1'b0, 16'h0010, 24'h000000, 24'hBBBFBB};
        vecs[5] = '{0, 1'b1, 16'hFFFF, 24'hABCDEF, 24'h000000};
        vecs[6] = '{1, 1'b0, 16'hFFFF, 24'h000000, 24'hABCDEF};
        mem[16'h0005] = 24'h123456;
        exp_gc[0] = 0;
        exp_gc[1] = 0;

        // Reset state, including a pending request that must not be granted.
        #2 rst = 1'b1;
        req_valid = 2'b01;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_enables", 32'({read_enable, write_enable}), 0);
        chk("rst_address", 32'(address), 0);
        chk("rst_w_data", 32'(w_data), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        req_valid = '0;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) do_txn(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);

        // Both requesters held valid: grants alternate every 4 cycles.
        @(negedge clk);
        req_write = '0;
        req_addr  = {16'h0010, 16'h0005};
        req_valid = 2'b11;
        last = 0;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int k = 0; k < 12 && !got; k++) begin
                #1;
                if (req_ready != '0) got = 1'b1;
                else @(negedge clk);
            end
            chk($sformatf("rr_grant_%0d", g), 32'(req_ready), 32'(1 << (g % 2)));
            if (got) begin
                r = req_ready[1] ? 1 : 0;
                exp_gc[r]++;
                e.req = r; e.chk_data = 1'b1;
                e.rdata = (r == 0) ? 24'h123456 : 24'hBBBFBB;
                sbq.push_back(e);
                if (g > 0) chk($sformatf("rr_period_%0d", g), 32'(cyc - last), 4);
                last = cyc;
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (4) @(negedge clk);

        // Reset during the first access cycle of a req0 read (pointer now at 1).
        req_addr[0 +: AW] = 16'h0005;
        req_valid = 2'b01;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            #1;
            if (req_ready[0]) got = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_grant", 32'(got), 1);
        @(posedge clk);
        #1;
        chk("rst_mid_pre_rd_en", 32'(read_enable), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_enables", 32'({read_enable, write_enable}), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        exp_gc[0] = 0;
        exp_gc[1] = 0;
        req_valid = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", 32'(rsp_valid), 0);
        end
        rst = 1'b0;
        req_addr  = {16'h0005, 16'h0010};
        req_valid = 2'b11;
        #1;
        chk("post_rst_first_grant", 32'(req_ready), 32'b01);
        if (req_ready == 2'b01) begin
            exp_gc[0]++;
            e.req = 0; e.chk_data = 1'b1; e.rdata = 24'hBBBFBB;
            sbq.push_back(e);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (6) @(negedge clk);

`ifdef SRAM_ARB_STATS_EN
        for (int i = 0; i < 3; i++) do_txn(0, 1'b0, 16'h0005, 24'h0, 24'h123456);
        #1;
        chk("grant_count_0", 32'(grant_count[15:0]), 32'(exp_gc[0]));
        chk("grant_count_1", 32'(grant_count[31:16]), 32'(exp_gc[1]));
`endif

        chk("sb_drained", 32'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
